// File: rtl/rv_pkg.sv
// Shared constants and types for the ID/EX operand stage.
// Optional operand bypassing is enabled by defining RV_FWD_EN.
package rv_pkg;

    localparam int unsigned XLEN_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 4;

    // ALU opcodes: {bit30 qualifier, funct3}
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;

    // Operand A source select; 2'b11 aliases to rs1
    localparam logic [1:0] A_SEL_RS1  = 2'b00;
    localparam logic [1:0] A_SEL_PC   = 2'b01;
    localparam logic [1:0] A_SEL_ZERO = 2'b10;

    // Operand B source select
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    // Registered payload handed to the execute stage
    typedef struct packed {
        logic [XLEN_W-1:0]     a;
        logic [XLEN_W-1:0]     b;
        logic [XLEN_W-1:0]     store_data;
        logic [XLEN_W-1:0]     pc;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [ALU_OP_W-1:0]   alu_op;
    } id_ex_payload_t;

    // Bit 30 only qualifies SUB (R-type) and SRA/SRAI (funct3 101)
    function automatic logic [ALU_OP_W-1:0] alu_op_decode(
        input logic       force_add,
        input logic [2:0] funct3,
        input logic       funct7b5,
        input logic       is_reg_op
    );
        logic qual;
        qual = funct7b5 & (is_reg_op | (funct3 == 3'b101));
        return force_add ? ALU_ADD : {qual, funct3};
    endfunction

endpackage

// File: rtl/rv_fwd_mux.sv
// Source-operand bypass select: EX over WB over register file; x0 is always 0.
// Bypassing is compiled in only when RV_FWD_EN is defined.
module rv_fwd_mux
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            ex_fwd_valid,
    input  logic [4:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic [XLEN-1:0] rs_fwd_c
);

`ifdef RV_FWD_EN
    // Newest producer wins; x0 is never bypassed
    always_comb begin
        rs_fwd_c = rs_data;
        if (rs_addr == 5'd0) begin
            rs_fwd_c = '0;
        end else if (ex_fwd_valid && (ex_fwd_rd == rs_addr)) begin
            rs_fwd_c = ex_fwd_data;
        end else if (wb_fwd_valid && (wb_fwd_rd == rs_addr)) begin
            rs_fwd_c = wb_fwd_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_data};

    // Register-file data only, with x0 forced to zero
    always_comb begin
        rs_fwd_c = rs_data;
        if (rs_addr == 5'd0) begin
            rs_fwd_c = '0;
        end
    end
`endif

endmodule

// File: rtl/rv_id_ex_stage.sv
// ID/EX pipeline register: resolves operands, decodes the ALU opcode and
// holds one instruction behind a valid/ready handshake.
// Define RV_FWD_EN to enable EX/WB operand bypassing.
module rv_id_ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_is_reg_op,
    input  logic            in_force_add,
    input  logic [1:0]      in_a_sel,
    input  logic            in_b_sel,
    input  logic            flush,
    input  logic            ex_fwd_valid,
    input  logic [4:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A_in,
    output logic [XLEN-1:0] B_in,
    output logic [3:0]      alu_op,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc
);

    logic            out_valid_d, out_valid_q;
    id_ex_payload_t  payload_d, payload_q;
    logic [XLEN-1:0] rs1_fwd_c, rs2_fwd_c;
    logic [XLEN-1:0] a_mux_c, b_mux_c;
    logic            capture_c;

    rv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr      (in_rs1_addr),
        .rs_data      (in_rs1_data),
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_rd    (ex_fwd_rd),
        .ex_fwd_data  (ex_fwd_data),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .rs_fwd_c     (rs1_fwd_c)
    );

    rv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr      (in_rs2_addr),
        .rs_data      (in_rs2_data),
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_rd    (ex_fwd_rd),
        .ex_fwd_data  (ex_fwd_data),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .rs_fwd_c     (rs2_fwd_c)
    );

    assign in_ready  = ~out_valid_q | out_ready;
    assign capture_c = in_valid & in_ready & ~flush;

    // Operand source selection
    always_comb begin
        a_mux_c = rs1_fwd_c;
        case (in_a_sel)
            A_SEL_PC:   a_mux_c = in_pc;
            A_SEL_ZERO: a_mux_c = '0;
            default:    a_mux_c = rs1_fwd_c;
        endcase
        b_mux_c = (in_b_sel == B_SEL_IMM) ? in_imm : rs2_fwd_c;
    end

    // Handshake and payload next state; flush beats capture, stall holds
    always_comb begin
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture_c) begin
            out_valid_d          = 1'b1;
            payload_d.a          = XLEN_W'(a_mux_c);
            payload_d.b          = XLEN_W'(b_mux_c);
            payload_d.store_data = XLEN_W'(rs2_fwd_c);
            payload_d.pc         = XLEN_W'(in_pc);
            payload_d.rd_addr    = in_rd_addr;
            payload_d.alu_op     = alu_op_decode(in_force_add, in_funct3,
                                                 in_funct7b5, in_is_reg_op);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign A_in           = XLEN'(payload_q.a);
    assign B_in           = XLEN'(payload_q.b);
    assign out_store_data = XLEN'(payload_q.store_data);
    assign out_pc         = XLEN'(payload_q.pc);
    assign out_rd_addr    = payload_q.rd_addr;
    assign alu_op         = payload_q.alu_op;

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// Directed bench for rv_id_ex_stage: vector table plus stall/flush/reset sequences.
module tb_rv_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [2:0]  in_funct3;
    logic        in_funct7b5, in_is_reg_op, in_force_add, in_b_sel;
    logic [1:0]  in_a_sel;
    logic        flush;
    logic        ex_fwd_valid, wb_fwd_valid;
    logic [4:0]  ex_fwd_rd, wb_fwd_rd;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] A_in, B_in, out_store_data, out_pc;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd_addr;

    int n_vec = 0;
    int n_err = 0;

    rv_id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_imm(in_imm), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_is_reg_op(in_is_reg_op), .in_force_add(in_force_add),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .flush(flush),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_in(A_in), .B_in(B_in), .alu_op(alu_op), .out_rd_addr(out_rd_addr),
        .out_store_data(out_store_data), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        b30, reg_op, force_add, b_sel;
        logic [1:0]  a_sel;
        logic        ex_v, wb_v;
        logic [4:0]  ex_rd, wb_rd;
        logic [31:0] ex_d, wb_d;
        logic [31:0] exp_a, exp_b, exp_store;
        logic [3:0]  exp_op;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string name, input logic [31:0] pc,
        input logic [4:0] rs1, input logic [31:0] rs1_data,
        input logic [4:0] rs2, input logic [31:0] rs2_data,
        input logic [4:0] rd, input logic [31:0] imm,
        input logic [2:0] f3, input logic b30, input logic reg_op, input logic force_add,
        input logic [1:0] a_sel, input logic b_sel,
        input logic [31:0] exp_a, input logic [31:0] exp_b,
        input logic [31:0] exp_store, input logic [3:0] exp_op);
        vec_t v;
        v.name = name; v.pc = pc; v.rs1 = rs1; v.rs1_data = rs1_data;
        v.rs2 = rs2; v.rs2_data = rs2_data; v.rd = rd; v.imm = imm;
        v.f3 = f3; v.b30 = b30; v.reg_op = reg_op; v.force_add = force_add;
        v.a_sel = a_sel; v.b_sel = b_sel;
        v.ex_v = 1'b0; v.ex_rd = 5'd0; v.ex_d = 32'd0;
        v.wb_v = 1'b0; v.wb_rd = 5'd0; v.wb_d = 32'd0;
        v.exp_a = exp_a; v.exp_b = exp_b; v.exp_store = exp_store; v.exp_op = exp_op;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_pc = v.pc; in_rs1_addr = v.rs1; in_rs1_data = v.rs1_data;
        in_rs2_addr = v.rs2; in_rs2_data = v.rs2_data; in_rd_addr = v.rd;
        in_imm = v.imm; in_funct3 = v.f3; in_funct7b5 = v.b30;
        in_is_reg_op = v.reg_op; in_force_add = v.force_add;
        in_a_sel = v.a_sel; in_b_sel = v.b_sel;
        ex_fwd_valid = v.ex_v; ex_fwd_rd = v.ex_rd; ex_fwd_data = v.ex_d;
        wb_fwd_valid = v.wb_v; wb_fwd_rd = v.wb_rd; wb_fwd_data = v.wb_d;
    endtask

    task automatic check_out(input vec_t v);
        chk({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, ".A_in"}, A_in, v.exp_a);
        chk({v.name, ".B_in"}, B_in, v.exp_b);
        chk({v.name, ".alu_op"}, 32'(alu_op), 32'(v.exp_op));
        chk({v.name, ".store"}, out_store_data, v.exp_store);
        chk({v.name, ".rd"}, 32'(out_rd_addr), 32'(v.rd));
        chk({v.name, ".pc"}, out_pc, v.pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] fwd_a, fwd_b;

        //           name      pc        rs1 data          rs2 data          rd  imm           f3    b30  reg fadd a_sel b_sel exp_a         exp_b         exp_store     op
        vecs.push_back(mk("sub",   32'h100, 5'd5, 32'd10,       5'd6, 32'd3,       5'd7, 32'd0,        3'b000, 1, 1, 0, 2'b00, 0, 32'd10,       32'd3,        32'd3,        4'b1000));
        vecs.push_back(mk("addi",  32'h104, 5'd1, 32'h20,       5'd2, 32'h55,      5'd3, 32'hFFFFFC00, 3'b000, 1, 0, 0, 2'b00, 1, 32'h20,       32'hFFFFFC00, 32'h55,       4'b0000));
        vecs.push_back(mk("srai",  32'h108, 5'd3, 32'h80000000, 5'd4, 32'h9,       5'd5, 32'd3,        3'b101, 1, 0, 0, 2'b00, 1, 32'h80000000, 32'd3,        32'h9,        4'b1101));
        vecs.push_back(mk("srli",  32'h10C, 5'd3, 32'h80000000, 5'd4, 32'h9,       5'd5, 32'd4,        3'b101, 0, 0, 0, 2'b00, 1, 32'h80000000, 32'd4,        32'h9,        4'b0101));
        vecs.push_back(mk("sltiu", 32'h110, 5'd8, 32'h7,        5'd9, 32'h1,       5'd6, 32'hFFFFF800, 3'b011, 1, 0, 0, 2'b00, 1, 32'h7,        32'hFFFFF800, 32'h1,        4'b0011));
        vecs.push_back(mk("xor",   32'h114, 5'd8, 32'hF0F0,     5'd9, 32'h0FF0,    5'd6, 32'd0,        3'b100, 0, 1, 0, 2'b00, 0, 32'hF0F0,     32'h0FF0,     32'h0FF0,     4'b0100));
        vecs.push_back(mk("sw",    32'h118, 5'd10,32'h1000,     5'd11,32'hDEAD,    5'd0, 32'd8,        3'b010, 1, 1, 1, 2'b00, 1, 32'h1000,     32'd8,        32'hDEAD,     4'b0000));
        vecs.push_back(mk("auipc", 32'h2000,5'd12,32'h3,        5'd13,32'h4,       5'd14,32'h1000,     3'b000, 0, 0, 1, 2'b01, 1, 32'h2000,     32'h1000,     32'h4,        4'b0000));
        vecs.push_back(mk("lui",   32'h2004,5'd12,32'h3,        5'd13,32'h4,       5'd14,32'h12345000, 3'b111, 1, 1, 1, 2'b10, 1, 32'd0,        32'h12345000, 32'h4,        4'b0000));
        vecs.push_back(mk("asel3", 32'h2008,5'd15,32'h77,       5'd16,32'h66,      5'd17,32'd0,        3'b110, 0, 1, 0, 2'b11, 0, 32'h77,       32'h66,       32'h66,       4'b0110));
        vecs.push_back(mk("x0",    32'h200C,5'd0, 32'hFFFF,     5'd0, 32'h1234,    5'd1, 32'd0,        3'b111, 0, 1, 0, 2'b00, 0, 32'd0,        32'd0,        32'd0,        4'b0111));

`ifdef RV_FWD_EN
        fwd_a = 32'hAA; fwd_b = 32'hCC;
`else
        fwd_a = 32'h11; fwd_b = 32'h22;
`endif
        v = mk("fwd", 32'h3000, 5'd7, 32'h11, 5'd8, 32'h22, 5'd9, 32'd0,
               3'b000, 0, 1, 0, 2'b00, 0, fwd_a, fwd_b, fwd_b, 4'b0000);
        v.ex_v = 1'b1; v.ex_rd = 5'd7; v.ex_d = 32'hAA;
        v.wb_v = 1'b1; v.wb_rd = 5'd8; v.wb_d = 32'hCC;
        vecs.push_back(v);
        v = mk("fwd_ex_over_wb", 32'h3004, 5'd7, 32'h11, 5'd8, 32'h22, 5'd9, 32'd0,
               3'b000, 0, 1, 0, 2'b00, 0, fwd_a, 32'h22, 32'h22, 4'b0000);
        v.ex_v = 1'b1; v.ex_rd = 5'd7; v.ex_d = 32'hAA;
        v.wb_v = 1'b1; v.wb_rd = 5'd7; v.wb_d = 32'hBB;
        vecs.push_back(v);
        v = mk("fwd_x0", 32'h3008, 5'd0, 32'h5, 5'd8, 32'h22, 5'd9, 32'd0,
               3'b000, 0, 1, 0, 2'b00, 0, 32'd0, 32'h22, 32'h22, 4'b0000);
        v.ex_v = 1'b1; v.ex_rd = 5'd0; v.ex_d = 32'h99;
        v.wb_v = 1'b1; v.wb_rd = 5'd0; v.wb_d = 32'h98;
        vecs.push_back(v);

        // Reset state, with downstream not ready
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        drive(vecs[0]);
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.A_in", A_in, 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // Streaming table
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            tick();
            check_out(vecs[i]);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Stall: hold for 3 cycles, no re-forwarding of held data
        drive(vecs[0]); in_valid = 1'b1;
        tick();
        check_out(vecs[0]);
        out_ready = 1'b0;
        drive(vecs[1]);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'hEE;
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall.in_ready_c", 32'(in_ready), 32'd0);
            check_out(vecs[0]);
        end
        ex_fwd_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("unstall.in_ready", 32'(in_ready), 32'd1);
        tick();
        check_out(vecs[1]);

        // Flush with in_valid on the same cycle
        drive(vecs[2]); in_valid = 1'b1; flush = 1'b1;
        tick();
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Flush while stalled
        tick();
        check_out(vecs[2]);
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        chk("flush_stall.out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Asynchronous reset mid-stall
        drive(vecs[3]); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check_out(vecs[3]);
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.A_in", A_in, 32'd0);
        chk("arst.out_pc", out_pc, 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
